// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: T-state indices, IR field positions, PC reset default.
package instruction_fetch_sequencer_pkg;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  byte_t;

  localparam int T0_IDX = 0;
  localparam int T1_IDX = 1;
  localparam int T2_IDX = 2;

  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 10;
  localparam int RSEL_MSB    = 9;
  localparam int RSEL_LSB    = 8;
  localparam int ADDRESS_MSB = 7;
  localparam int ADDRESS_LSB = 0;
  localparam int S_BIT_POS   = 9;
  localparam int DST_MSB     = 8;
  localparam int DST_LSB     = 6;
  localparam int SRC1_MSB    = 5;
  localparam int SRC1_LSB    = 3;
  localparam int SRC2_MSB    = 2;
  localparam int SRC2_LSB    = 0;

  localparam word_t PC_RESET_DEFAULT = 16'h0000;

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Byte-wide instruction memory read port between the sequencer (master) and memory (slave).
interface instruction_fetch_sequencer_if;
  import instruction_fetch_sequencer_pkg::*;

  word_t Mem_Addr;
  logic  Mem_Rd;
  byte_t Mem_Data;

  modport master (output Mem_Addr, output Mem_Rd, input Mem_Data);
  modport slave  (input Mem_Addr, input Mem_Rd, output Mem_Data);

endinterface

// File: rtl/instruction_fetch_sequencer_seq_counter.sv
// One-hot T-state shift counter; Clear returns to T0, Wrap flags a natural rollover from the last state.
module seq_counter #(
  parameter int T_WIDTH = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Hold,
  input  logic               Clear,
  output logic [T_WIDTH-1:0] T,
  output logic               Wrap
);

  localparam logic [T_WIDTH-1:0] T_INIT = {{(T_WIDTH-1){1'b0}}, 1'b1};

  logic [T_WIDTH-1:0] t_q;
  logic [T_WIDTH-1:0] t_next;

  always_ff @(posedge Clock) begin
    if (Reset) t_q <= T_INIT;
    else       t_q <= t_next;
  end

  always_comb begin
    t_next = t_q;
    if (!Hold) begin
      if (Clear) t_next = T_INIT;
      else       t_next = {t_q[T_WIDTH-2:0], t_q[T_WIDTH-1]};
    end
  end

  always_comb begin
    T    = t_q;
    Wrap = t_q[T_WIDTH-1] & ~Hold & ~Clear;
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch front end: owns PC, assembles 16-bit IR from two memory bytes, sequences T states.
// Optional retired-instruction counter enabled by defining RETIRE_COUNT_EN.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int    T_WIDTH  = 8,
  parameter word_t PC_RESET = PC_RESET_DEFAULT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  instruction_fetch_sequencer_if.master bus,
  input  logic                 Hold,
  input  logic                 Exec_Done,
  input  logic                 PC_Load,
  input  word_t                PC_Load_Value,
  output word_t                PC_Out,
  output word_t                IR_Out,
  output logic [T_WIDTH-1:0]   T,
  output logic                 Instr_Valid,
  output logic [5:0]           Opcode,
  output logic [1:0]           RSel,
  output logic [7:0]           Address,
  output logic                 S_Bit,
  output logic [2:0]           DstReg,
  output logic [2:0]           SReg1,
  output logic [2:0]           SReg2,
`ifdef RETIRE_COUNT_EN
  output logic [31:0]          Retired,
`endif
  output logic                 Timeout
);

  word_t pc_q;
  word_t ir_q;
  logic  timeout_q;
  logic  fetch_lo;
  logic  fetch_hi;
  logic  in_exec;
  logic  done_accept;
  logic  wrap;

  seq_counter #(.T_WIDTH(T_WIDTH)) u_seq_counter (
    .Clock (Clock),
    .Reset (Reset),
    .Hold  (Hold),
    .Clear (done_accept),
    .T     (T),
    .Wrap  (wrap)
  );

  assign fetch_lo    = T[T0_IDX];
  assign fetch_hi    = T[T1_IDX];
  assign in_exec     = ~(fetch_lo | fetch_hi);
  assign done_accept = Exec_Done & ~Hold & in_exec;

  // During fetch the increment always wins over a branch load.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      timeout_q <= 1'b0;
    end else if (!Hold) begin
      if (fetch_lo) begin
        ir_q[7:0] <= bus.Mem_Data;
        pc_q      <= pc_q + 16'd1;
      end else if (fetch_hi) begin
        ir_q[15:8] <= bus.Mem_Data;
        pc_q       <= pc_q + 16'd1;
      end else if (PC_Load) begin
        pc_q <= PC_Load_Value;
      end
      if (wrap) timeout_q <= 1'b1;
    end
  end

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge Clock) begin
    if (Reset)            Retired <= '0;
    else if (done_accept) Retired <= Retired + 32'd1;
  end
`endif

  assign bus.Mem_Addr = pc_q;
  assign bus.Mem_Rd   = (fetch_lo | fetch_hi) & ~Hold;

  assign PC_Out      = pc_q;
  assign IR_Out      = ir_q;
  assign Instr_Valid = in_exec;
  assign Timeout     = timeout_q;

  assign Opcode  = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign RSel    = ir_q[RSEL_MSB:RSEL_LSB];
  assign Address = ir_q[ADDRESS_MSB:ADDRESS_LSB];
  assign S_Bit   = ir_q[S_BIT_POS];
  assign DstReg  = ir_q[DST_MSB:DST_LSB];
  assign SReg1   = ir_q[SRC1_MSB:SRC1_LSB];
  assign SReg2   = ir_q[SRC2_MSB:SRC2_LSB];

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with hand-computed expected values.
module tb_instruction_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Hold;
  logic        Exec_Done;
  logic        PC_Load;
  logic [15:0] PC_Load_Value;
  logic [15:0] PC_Out;
  logic [15:0] IR_Out;
  logic [7:0]  T;
  logic        Instr_Valid;
  logic [5:0]  Opcode;
  logic [1:0]  RSel;
  logic [7:0]  Address;
  logic        S_Bit;
  logic [2:0]  DstReg;
  logic [2:0]  SReg1;
  logic [2:0]  SReg2;
  logic        Timeout;
`ifdef RETIRE_COUNT_EN
  logic [31:0] Retired;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  instruction_fetch_sequencer_if bus ();
  assign bus.Mem_Data = mem[bus.Mem_Addr];

  instruction_fetch_sequencer #(.T_WIDTH(8), .PC_RESET(16'h0000)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .bus           (bus),
    .Hold          (Hold),
    .Exec_Done     (Exec_Done),
    .PC_Load       (PC_Load),
    .PC_Load_Value (PC_Load_Value),
    .PC_Out        (PC_Out),
    .IR_Out        (IR_Out),
    .T             (T),
    .Instr_Valid   (Instr_Valid),
    .Opcode        (Opcode),
    .RSel          (RSel),
    .Address       (Address),
    .S_Bit         (S_Bit),
    .DstReg        (DstReg),
    .SReg1         (SReg1),
    .SReg2         (SReg2),
`ifdef RETIRE_COUNT_EN
    .Retired       (Retired),
`endif
    .Timeout       (Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h0000] = 8'h34;
    mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h78;
    mem[16'h0003] = 8'h56;
    mem[16'h0040] = 8'hAA;
    mem[16'h0041] = 8'hBB;
    mem[16'h0044] = 8'hC3;
    mem[16'h0045] = 8'h3C;
    mem[16'hFFFF] = 8'hEE;

    Reset = 1'b1; Hold = 1'b0; Exec_Done = 1'b0; PC_Load = 1'b0; PC_Load_Value = 16'h0000;
    tick(); tick();
    check("rst_pc", PC_Out, 32'h0000);
    check("rst_ir", IR_Out, 32'h0000);
    check("rst_t", T, 32'h01);
    check("rst_timeout", Timeout, 0);
    check("rst_valid", Instr_Valid, 0);
    check("rst_mem_rd", bus.Mem_Rd, 1);
`ifdef RETIRE_COUNT_EN
    check("rst_retired", Retired, 0);
`endif
    Reset = 1'b0;

    // First fetch from bytes 0,1
    tick(); tick();
    check("t1_ir", IR_Out, 32'h1234);
    check("t1_pc", PC_Out, 32'h0002);
    check("t1_t", T, 32'h04);
    check("t1_opcode", Opcode, 32'h04);
    check("t1_rsel", RSel, 32'h2);
    check("t1_address", Address, 32'h34);
    check("t1_valid", Instr_Valid, 1);
    check("t1_mem_rd", bus.Mem_Rd, 0);

    // Exec_Done in T3
    tick();
    check("t2_t3", T, 32'h08);
    Exec_Done = 1'b1;
    tick();
    Exec_Done = 1'b0;
    check("t2_t", T, 32'h01);
    check("t2_addr", bus.Mem_Addr, 32'h0002);
    check("t2_mem_rd", bus.Mem_Rd, 1);
    check("t2_valid", Instr_Valid, 0);
    tick(); tick();
    check("t2_ir", IR_Out, 32'h5678);
    check("t2_pc", PC_Out, 32'h0004);
    check("t2_sbit", S_Bit, 1);
    check("t2_dst", DstReg, 32'h1);
    check("t2_src1", SReg1, 32'h7);
    check("t2_src2", SReg2, 32'h0);

    // Branch with Exec_Done in T2, then PC_Load in T0 ignored
    PC_Load = 1'b1; PC_Load_Value = 16'h0040; Exec_Done = 1'b1;
    tick();
    Exec_Done = 1'b0; PC_Load_Value = 16'h0099;
    check("t3_t", T, 32'h01);
    check("t3_addr", bus.Mem_Addr, 32'h0040);
    tick();
    PC_Load = 1'b0;
    check("t3_pc_ignore", PC_Out, 32'h0041);
    check("t3_t1", T, 32'h02);
    tick();
    check("t3_pc", PC_Out, 32'h0042);
    check("t3_ir", IR_Out, 32'hBBAA);

    // No Exec_Done: wrap from T7 sets sticky Timeout
    repeat (5) tick();
    check("t4_t7", T, 32'h80);
    check("t4_no_timeout", Timeout, 0);
    tick();
    check("t4_wrap", T, 32'h01);
    check("t4_timeout", Timeout, 1);
    tick(); tick();
    check("t4_timeout_sticky", Timeout, 1);
    check("t4_pc", PC_Out, 32'h0044);
    check("t4_t", T, 32'h04);

    // Hold in T1
    Exec_Done = 1'b1;
    tick();
    Exec_Done = 1'b0;
    tick();
    check("t5_t1", T, 32'h02);
    Hold = 1'b1;
    repeat (3) tick();
    check("t5_hold_pc", PC_Out, 32'h0045);
    check("t5_hold_t", T, 32'h02);
    check("t5_hold_ir", IR_Out, 32'h19C3);
    check("t5_hold_rd", bus.Mem_Rd, 0);
    Hold = 1'b0;
    tick();
    check("t5_ir", IR_Out, 32'h3CC3);
    check("t5_pc", PC_Out, 32'h0046);
    check("t5_t", T, 32'h04);

    // Hold beats Exec_Done and PC_Load
    Hold = 1'b1; Exec_Done = 1'b1; PC_Load = 1'b1; PC_Load_Value = 16'h1234;
    tick();
    Hold = 1'b0; Exec_Done = 1'b0; PC_Load = 1'b0;
    check("hp_t", T, 32'h04);
    check("hp_pc", PC_Out, 32'h0046);

    // PC wrap at 16'hFFFF
    PC_Load = 1'b1; PC_Load_Value = 16'hFFFF; Exec_Done = 1'b1;
    tick();
    PC_Load = 1'b0; Exec_Done = 1'b0;
    check("t6_pc_ffff", PC_Out, 32'hFFFF);
    tick();
    check("t6_pc_wrap", PC_Out, 32'h0000);
    tick();
    check("t6_pc", PC_Out, 32'h0001);
    check("t6_ir", IR_Out, 32'h34EE);
    check("t6_timeout", Timeout, 1);

    // Reset during T1 discards partial fetch
    PC_Load = 1'b1; PC_Load_Value = 16'hFFFF; Exec_Done = 1'b1;
    tick();
    PC_Load = 1'b0; Exec_Done = 1'b0;
    tick();
    check("t6_mid_t", T, 32'h02);
`ifdef RETIRE_COUNT_EN
    check("retired", Retired, 5);
`endif
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_rst_pc", PC_Out, 32'h0000);
    check("t6_rst_ir", IR_Out, 32'h0000);
    check("t6_rst_t", T, 32'h01);
    check("t6_rst_timeout", Timeout, 0);
    check("t6_rst_valid", Instr_Valid, 0);
`ifdef RETIRE_COUNT_EN
    check("retired_rst", Retired, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
